// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: segment table, register
// field positions and default timing.
package seg_pkg;

  localparam int DEF_CLK_DIV   = 100000;
  localparam int DEF_BLANK_CYC = 1000;

  localparam int F_HEX_LSB = 0;
  localparam int F_EN_LSB  = 16;
  localparam int F_DP_LSB  = 20;
  localparam int F_LZS_BIT = 24;
  localparam int REG_W     = F_LZS_BIT + 1;

  // Display register image, packed to match wr_data[24:0].
  typedef struct packed {
    logic        lzs;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic [15:0] hex;
  } disp_reg_t;

  // Active-low g..a patterns, entry F first so SEG_LUT[n] decodes nibble n.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

endpackage

// File: rtl/seg_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG_LUT[nib];

endmodule

// File: rtl/seg_scan.sv
// Four-digit multiplexed seven-segment scanner with a shadow register that
// is committed only at frame boundaries so a frame never shows mixed values.
module seg_scan
  import seg_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int BLANK_CYC = DEF_BLANK_CYC
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic [3:0]  AN,
  output logic [7:0]  BCD,
  output logic        frame_tick
);

  localparam int            PW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST   = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYC);

  // True when every nibble from the current digit upward is zero.
  function automatic logic hi_zero(input logic [15:0] hex, input logic [1:0] dig);
    logic z;
    case (dig)
      2'd3:    z = (hex[15:12] == 4'h0);
      2'd2:    z = (hex[15:8] == 8'h00);
      2'd1:    z = (hex[15:4] == 12'h000);
      default: z = 1'b0;
    endcase
    return z;
  endfunction

  logic [PW-1:0] ps_p0;
  logic [1:0]    dig_p0;
  logic          wrap_p0;
  logic          frame_end_p0;
  logic          blank_p0;

  disp_reg_t shadow, active;
  disp_reg_t shd_wr, shd_nxt, act_nxt;
  logic      pending, pend_nxt;

  logic [3:0] nib_p0;
  logic [6:0] seg7_p0;
  logic       suppress_p0;
  logic [3:0] an_nxt;
  logic [7:0] bcd_nxt;

  logic [3:0] an_p1;
  logic [7:0] bcd_p1;
  logic       tick_p1;

  logic unused_hi;
  assign unused_hi = ^wr_data[31:REG_W];

  // ---- stage p0: prescaler and digit index ----
  assign wrap_p0      = (ps_p0 == PS_LAST);
  assign frame_end_p0 = wrap_p0 && (dig_p0 == 2'd3);
  assign blank_p0     = (ps_p0 < BLANK_END);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ps_p0  <= '0;
      dig_p0 <= 2'd0;
    end else if (wrap_p0) begin
      ps_p0  <= '0;
      dig_p0 <= dig_p0 + 2'd1;
    end else begin
      ps_p0  <= ps_p0 + PW'(1);
    end
  end

  // Commit happens on the frame_tick cycle; a write landing on that same
  // cycle goes straight through to the active register.
  assign shd_wr = '{lzs: wr_data[F_LZS_BIT],
                    dp:  wr_data[F_DP_LSB +: 4],
                    en:  wr_data[F_EN_LSB +: 4],
                    hex: wr_data[F_HEX_LSB +: 16]};

  always_comb begin
    shd_nxt  = shadow;
    act_nxt  = active;
    pend_nxt = pending;
    if (wr_en) begin
      shd_nxt  = shd_wr;
      pend_nxt = 1'b1;
    end
    if (tick_p1 && pend_nxt) begin
      act_nxt  = shd_nxt;
      pend_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else begin
      shadow  <= shd_nxt;
      active  <= act_nxt;
      pending <= pend_nxt;
    end
  end

  assign rd_data = {{(32 - REG_W){1'b0}}, shadow};

  // Decode from act_nxt so even a zero-length blank window shows the
  // freshly committed frame on digit 0.
  assign nib_p0      = act_nxt.hex[{dig_p0, 2'b00} +: 4];
  assign suppress_p0 = act_nxt.lzs && hi_zero(act_nxt.hex, dig_p0);

  seg_decode u_decode (
    .nib (nib_p0),
    .seg (seg7_p0)
  );

  always_comb begin
    an_nxt  = 4'hF;
    bcd_nxt = 8'hFF;
    if (!blank_p0) begin
      if (act_nxt.en[dig_p0]) begin
        an_nxt = ~(4'b0001 << dig_p0);
      end
      if (!suppress_p0) begin
        bcd_nxt = {~act_nxt.dp[dig_p0], seg7_p0};
      end
    end
  end

  // ---- stage p1: glitch-free pin registers ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an_p1   <= 4'hF;
      bcd_p1  <= 8'hFF;
      tick_p1 <= 1'b0;
    end else begin
      an_p1   <= an_nxt;
      bcd_p1  <= bcd_nxt;
      tick_p1 <= frame_end_p0;
    end
  end

  assign AN         = an_p1;
  assign BCD        = bcd_p1;
  assign frame_tick = tick_p1;

endmodule

// File: tb/tb_seg_scan.sv
// Randomised and directed bench for seg_scan against a cycle-count based
// reference model.
module tb_seg_scan;

  localparam int CLK_DIV   = 8;
  localparam int BLANK_CYC = 2;
  localparam int FRAME     = 4 * CLK_DIV;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_data = 32'h0;
  logic [31:0] rd_data;
  logic [3:0]  AN;
  logic [7:0]  BCD;
  logic        frame_tick;

  seg_scan #(
    .CLK_DIV   (CLK_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .rd_data    (rd_data),
    .AN         (AN),
    .BCD        (BCD),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Reference state: n counts clock edges since reset release.
  int          n;
  logic [24:0] m_shadow;
  logic [24:0] m_active;
  bit          m_pend;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] seg_of(input logic [3:0] h);
    logic [7:0] t [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    return t[h];
  endfunction

  task automatic model_edge();
    bit ld;
    if (!reset_n) begin
      n = 0; m_shadow = '0; m_active = '0; m_pend = 0;
    end else begin
      ld = (n > 0) && (n % FRAME == 0);
      if (wr_en) begin
        m_shadow = wr_data[24:0];
        if (ld) begin
          m_active = wr_data[24:0];
          m_pend   = 0;
        end else begin
          m_pend = 1;
        end
      end else if (ld && m_pend) begin
        m_active = m_shadow;
        m_pend   = 0;
      end
      n++;
    end
  endtask

  task automatic compare_all();
    int s, cnt, dig;
    logic [3:0]  e_an;
    logic [7:0]  e_bcd;
    logic [15:0] upper;
    bit e_tick;
    e_an = 4'hF; e_bcd = 8'hFF; e_tick = 0;
    if (n > 0) begin
      s = n - 1;
      cnt = s % CLK_DIV;
      dig = (s / CLK_DIV) % 4;
      e_tick = (n % FRAME == 0);
      if (cnt >= BLANK_CYC) begin
        if (m_active[16 + dig]) e_an = 4'hF & ~(4'b0001 << dig);
        upper = m_active[15:0] >> (4 * dig);
        if (!(m_active[24] && dig != 0 && upper == 16'h0)) begin
          e_bcd = seg_of(m_active[4 * dig +: 4]);
          if (m_active[20 + dig]) e_bcd = e_bcd & 8'h7F;
        end
      end
    end
    check("AN", AN, e_an);
    check("BCD", BCD, e_bcd);
    check("frame_tick", frame_tick, e_tick);
    check("rd_data", rd_data, {7'b0, m_shadow});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic write(input logic [31:0] d);
    wr_en = 1'b1;
    wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic run_to(input int phase);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while ((n % FRAME != phase) && k < 3 * FRAME);
    if (n % FRAME != phase) check("run_to_timeout", n % FRAME, phase);
  endtask

  task automatic spot(input string tag, input int phase, input logic [3:0] an, input logic [7:0] bcd);
    run_to(phase);
    check({tag, "_AN"}, AN, an);
    check({tag, "_BCD"}, BCD, bcd);
  endtask

  initial begin
    n = 0; m_shadow = '0; m_active = '0; m_pend = 0;

    // Reset held for three cycles
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) step();
    reset_n = 1'b1;

    // Basic scan of 1234, all digits enabled
    write(32'h000F_1234);
    run_to(0);
    check("first_tick_cycle", n, FRAME);
    spot("s27_blank0", 1, 4'hF, 8'hFF);
    spot("s27_blank1", 2, 4'hF, 8'hFF);
    spot("s27_d0", 3, 4'hE, 8'h99);
    spot("s27_d1", 11, 4'hD, 8'hB0);
    spot("s27_d2", 19, 4'hB, 8'hA4);
    spot("s27_d3", 27, 4'h7, 8'hF9);

    // Tear-free update written during digit 1
    run_to(9);
    write(32'h000F_5678);
    check("s28_rd_now", rd_data, 32'h000F_5678);
    spot("s28_d1_old", 11, 4'hD, 8'hB0);
    spot("s28_d2_old", 19, 4'hB, 8'hA4);
    spot("s28_d3_old", 27, 4'h7, 8'hF9);
    spot("s28_d0_new", 3, 4'hE, 8'h80);
    spot("s28_d1_new", 11, 4'hD, 8'hF8);

    // Write coinciding with frame_tick goes straight through
    run_to(0);
    check("s29_tick", frame_tick, 1'b1);
    write(32'h000F_9ABC);
    spot("s29_d0", 3, 4'hE, 8'hC6);
    spot("s29_d3", 27, 4'h7, 8'h90);

    // Leading-zero suppress and decimal point
    write(32'h011F_0050);
    run_to(0);
    spot("s30_d0", 3, 4'hE, 8'h40);
    spot("s30_d1", 11, 4'hD, 8'h92);
    spot("s30_d2", 19, 4'hB, 8'hFF);
    spot("s30_d3", 27, 4'h7, 8'hFF);

    // Random writes at random phases
    for (int it = 0; it < 60; it++) begin
      int idle;
      idle = $urandom_range(0, 40);
      for (int j = 0; j < idle; j++) step();
      write($urandom);
    end
    for (int j = 0; j < 2 * FRAME; j++) step();

    // Mid-pending asynchronous reset discards the write
    run_to(5);
    write(32'h000F_4321);
    step();
    #2 reset_n = 1'b0;
    #1;
    check("s31_AN", AN, 4'hF);
    check("s31_BCD", BCD, 8'hFF);
    check("s31_rd", rd_data, 32'h0);
    check("s31_tick", frame_tick, 1'b0);
    step();
    step();
    reset_n = 1'b1;
    for (int j = 0; j < 3 * FRAME; j++) begin
      step();
      check("s31_dark", AN, 4'hF);
    end
    check("s31_rd_after", rd_data, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 SHALL have parameter CLK_DIV, default 100000, meaning clock cycles per digit slot (1 kHz slot rate at 100 MHz).
REQ-002 SHALL have parameter BLANK_CYC, default 1000, meaning cycles at the start of each slot with all anodes off (anti-ghosting); legal range 0 <= BLANK_CYC < CLK_DIV.
REQ-003 SHALL have port clk, input, 1 bit: system clock.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port wr_en, input, 1 bit: one-cycle write strobe from the data-memory peripheral decode.
REQ-006 SHALL have port wr_data, input, 32 bits, with these fields: [15:0] four hex nibbles, digit 0 = [3:0]; [19:16] digit enable mask; [23:20] decimal-point mask; [24] leading-zero suppress; [31:25] ignored.
REQ-007 SHALL have port rd_data, output, 32 bits: {7'b0, shadow register[24:0]}.
REQ-008 SHALL have port AN, output, 4 bits: anodes, active-low, AN[i] selects digit i.
REQ-009 SHALL have port BCD, output, 8 bits: segments, active-low; [7] is dp, [6:0] is g..a.
REQ-010 SHALL have port frame_tick, output, 1 bit: one-cycle pulse at each frame boundary.

Function
REQ-011 SHALL load wr_data[24:0] into the shadow register on any clk edge where wr_en=1, and set the pending flag.
REQ-012 SHALL copy the shadow register into the active register only at a frame boundary, i.e. the cycle the slot counter wraps from digit 3 to digit 0, when pending=1; pending then clears. This prevents tearing.
REQ-013 If wr_en coincides with a frame boundary, the block SHALL apply the newly written value at that boundary (write-through), leaving pending=0.
REQ-014 The prescaler SHALL count 0..CLK_DIV-1 and wrap. On wrap, the digit index SHALL advance 0->1->2->3->0.
REQ-015 frame_tick SHALL be 1 for exactly the cycle in which the digit index goes from 3 to 0.
REQ-016 While prescaler < BLANK_CYC, AN SHALL be 4'b1111 and BCD SHALL be 8'hFF.
REQ-017 Outside the blank window, AN SHALL drive the current digit low only if its enable bit is 1; otherwise AN SHALL be 4'b1111.
REQ-018 Segment decode SHALL be hex 0-F. For "0", [6:0] = 7'b1000000; for "8", [6:0] = 7'b0000000. BCD[7] SHALL be the inverted dp mask bit of the current digit.
REQ-019 Leading-zero suppress: with bit 24 set, digit i (i = 3..1) SHALL blank (BCD=8'hFF, AN unchanged) when nibble i and all higher nibbles are 0. Digit 0 SHALL never be suppressed.
REQ-020 AN and BCD SHALL be registered: one cycle of latency from the prescaler/index state to the pins, with no combinational glitches at the pins.
REQ-021 The prescaler SHALL be ceil(log2(CLK_DIV)) bits wide. The digit index SHALL be 2 bits and wrap naturally.

Reset
REQ-022 On reset_n=0, the block SHALL immediately clear the prescaler, digit index (0), shadow, active register and pending; and set AN=4'b1111, BCD=8'hFF, frame_tick=0.
REQ-023 Reset asserted mid-slot or mid-pending SHALL discard the pending write. After release, digit 0's slot SHALL begin with a full blank window.

Structure
REQ-024 Shared package seg_pkg SHALL hold the 16-entry hex-to-segment constant table, the wr_data field bit positions, and the default CLK_DIV/BLANK_CYC.
REQ-025 Hex decode SHALL be a separate combinational sub-module seg_decode (4-bit nibble in, 7-bit active-low segments out). The scan counter, register file and output registers SHALL remain in seg_scan.

Verification (CLK_DIV=8, BLANK_CYC=2)
REQ-026 Reset: hold reset_n=0 for 3 cycles. Require AN=1111, BCD=FF and rd_data=0; after release, frame_tick first pulses 32 cycles later.
REQ-027 Basic scan: write 0x000F_1234 with no mask, then wait one frame. Require in each slot 2 cycles of AN=1111, then 6 cycles with AN=1110/BCD=0x99 ("4"), 1101/0xB0 ("3"), 1011/0xA4 ("2"), 0111/0xF9 ("1").
REQ-028 Tear-free update: write 0x000F_5678 during digit 1 of a frame. Require the remaining digits of that frame to show 1234, the new value from the next frame, and rd_data=0x000F5678 immediately.
REQ-029 Simultaneous event: assert wr_en on the frame_tick cycle. Require the new value on digit 0 of the frame starting then.
REQ-030 Leading-zero/dp: write 0x011F_0050. Require digits 3 and 2 BCD=FF, digit 1 = "5" (0x92), digit 0 = "0" with dp lit (0x40).
REQ-031 Mid-pending reset: write, then pulse reset_n before the boundary. Require display dark and rd_data=0 afterward.
